// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter: IDLE -> XFER -> ACK, one access per 3 cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with m1 starvation guard.
module ram_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic       ram_re,
    input  logic [7:0] ram_rdata,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       grant_m1;
    logic       start;

    assign start = (state_q == IDLE) && (m0_req || m1_req);

`ifdef ARB_ROUND_ROBIN_EN
    // ptr_q = 1 means m1 holds priority for the next conflict
    logic ptr_q, ptr_d;

    assign grant_m1 = m1_req && (!m0_req || ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (start) begin
            ptr_d = !grant_m1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic [3:0] wait_q, wait_d;

    assign grant_m1 = m1_req && (!m0_req || (wait_q == 4'(MAX_WAIT)));

    // Count only conflicts m1 lost; an uncontested m0 grant leaves the count alone
    always_comb begin
        wait_d = wait_q;
        if (start) begin
            if (grant_m1) begin
                wait_d = 4'd0;
            end else if (m1_req) begin
                wait_d = wait_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = XFER;
                    owner_d = grant_m1 ? OWN_M1 : OWN_M0;
                    we_d    = grant_m1 ? m1_we : m0_we;
                    addr_d  = grant_m1 ? m1_addr : m0_addr;
                    wdata_d = grant_m1 ? m1_wdata : m0_wdata;
                end
            end
            XFER: begin
                state_d = ACK;
                if (!we_q) begin
                    if (owner_q == OWN_M1) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            we_q     <= 1'b0;
            addr_q   <= 8'd0;
            wdata_q  <= 8'd0;
            rdata0_q <= 8'd0;
            rdata1_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ram_we    = (state_q == XFER) && we_q;
    assign ram_re    = (state_q == XFER) && !we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_ack    = (state_q == ACK) && (owner_q == OWN_M0);
    assign m1_ack    = (state_q == ACK) && (owner_q == OWN_M1);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of single arbitrations plus hand-written reset/overlap/hold sequences.
// Acks are checked by a scoreboard monitor against expectations pushed when each request is driven.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int MAX_WAIT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_re;
    logic [1:0] owner;

    ram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // RAM model driven by the DUT, and an independent shadow used for expectations
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic       r0, we0; logic [7:0] a0, d0;
        logic       r1, we1; logic [7:0] a1, d1;
        logic       grant;
    } vec_t;

    typedef struct {
        logic       master;
        logic [7:0] rdata;
    } sb_t;

    sb_t        sb_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;
    vec_t       tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    function automatic vec_t mk(input logic r0, we0, input logic [7:0] a0, d0,
                                input logic r1, we1, input logic [7:0] a1, d1,
                                input logic grant);
        vec_t v;
        v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.grant = grant;
        return v;
    endfunction

    task automatic push_exp(input logic m, input logic we, input logic [7:0] a, input logic [7:0] d);
        sb_t e;
        e.master = m;
        if (we) begin
            shadow[a] = d;
            e.rdata = m ? exp_rd1 : exp_rd0;
        end else begin
            e.rdata = shadow[a];
            if (m) exp_rd1 = shadow[a];
            else   exp_rd0 = shadow[a];
        end
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we && ram_re) begin
                tests++; fails++;
                $display("FAIL strobe_overlap: ram_we=1 ram_re=1 required not both at %0t", $time);
            end
            if (m0_ack || m1_ack) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b required none at %0t", m0_ack, m1_ack, $time);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("sb_ack_m0", m0_ack, !e.master);
                    check("sb_ack_m1", m1_ack, e.master);
                    check("sb_rdata", e.master ? m1_rdata : m0_rdata, e.rdata);
                end
            end
        end
    end

    task automatic do_txn(input vec_t v);
        logic       wm1, we;
        logic [7:0] a, d;
        wm1 = v.grant;
        we  = wm1 ? v.we1 : v.we0;
        a   = wm1 ? v.a1 : v.a0;
        d   = wm1 ? v.d1 : v.d0;
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
        push_exp(wm1, we, a, d);
        @(posedge clk); #1;
        check("xfer_owner", owner, wm1 ? 2'b10 : 2'b01);
        check("xfer_ram_we", ram_we, we);
        check("xfer_ram_re", ram_re, !we);
        check("xfer_ram_addr", ram_addr, a);
        if (we) check("xfer_ram_wdata", ram_wdata, d);
        @(posedge clk); #1;
        check("ack_strobes", {ram_we, ram_re}, 2'b00);
        check("ack_winner", wm1 ? m1_ack : m0_ack, 1'b1);
        check("ack_loser", wm1 ? m0_ack : m1_ack, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        check("idle_owner", owner, 2'b00);
        check("idle_strobes", {ram_we, ram_re, m0_ack, m1_ack}, 4'b0000);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {owner, ram_we, ram_re, m0_ack, m1_ack}, 6'd0);
        check({tag, "_data"}, {ram_addr, ram_wdata, m0_rdata, m1_rdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10] = 8'hA5;
        shadow[8'h10] = 8'hA5;

        // Single accesses, 8 continuous conflicts, then read-backs
        tbl[0] = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        tbl[1] = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 1);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            tbl[2 + i] = mk(1, 0, 8'(8'h11 + i), 8'h00, 1, 1, 8'(8'h80 + i), 8'(8'hC0 + i), (i % 2) == 1);
`else
            tbl[2 + i] = mk(1, 0, 8'(8'h11 + i), 8'h00, 1, 1, 8'(8'h80 + i), 8'(8'hC0 + i), (i % 4) == 3);
`endif
        end
        tbl[10] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1);
        tbl[11] = mk(1, 1, 8'h10, 8'h55, 0, 0, 8'h00, 8'h00, 0);
        tbl[12] = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        reset = 1'b1;
        #3;
        check_all_zero("reset_state");
        #19;
        reset = 1'b0;

        foreach (tbl[i]) do_txn(tbl[i]);

        // Reset during an m0 write transfer aborts it; m0 then reissues
        m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h77;
        @(posedge clk); #1;
        check("rst_pre_ram_we", ram_we, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk); #1;
        check_all_zero("rst_held");
        @(posedge clk); #2;
        reset = 1'b0;
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        do_txn(mk(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 0));
        do_txn(mk(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0));

        // m1 raises its request while m0 is mid-transfer
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        push_exp(0, 0, 8'h10, 8'h00);
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_addr = 8'h30; m1_wdata = 8'h99;
        check("ovl_xfer_owner", owner, 2'b01);
        check("ovl_xfer_re", {ram_we, ram_re}, 2'b01);
        push_exp(1, 1, 8'h30, 8'h99);
        @(posedge clk); #1;
        check("ovl_ack_owner", owner, 2'b01);
        check("ovl_ack_m1", m1_ack, 1'b0);
        m0_req = 0;
        @(posedge clk); #1;
        check("ovl_idle_owner", owner, 2'b00);
        @(posedge clk); #1;
        check("ovl_m1_owner", owner, 2'b10);
        check("ovl_m1_we", {ram_we, ram_re}, 2'b10);
        check("ovl_m1_addr", ram_addr, 8'h30);
        @(posedge clk); #1;
        m1_req = 0;
        @(posedge clk); #1;

        // m1 alone, request held: one access every 3 cycles
        m1_req = 1; m1_we = 0; m1_addr = 8'h30;
        push_exp(1, 0, 8'h30, 8'h00);
        push_exp(1, 0, 8'h30, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("hold_ram_re", ram_re, (k == 0) || (k == 3));
            check("hold_m1_ack", m1_ack, (k == 1) || (k == 4));
            if (k == 4) m1_req = 0;
        end
        @(posedge clk); #1;

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
